mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter_store_lane_align.sv | 33 +++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: store size codes,
// default abort timeout and the grant-history type.
package mem_port_arbiter_pkg;

    localparam logic [1:0] BE_SB = 2'b00;
    localparam logic [1:0] BE_SH = 2'b01;
    localparam logic [1:0] BE_SW = 2'b10;

    localparam int unsigned TIMEOUT_DEFAULT = 15;

    typedef enum logic {
        GRANT_IF,
        GRANT_M
    } grant_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and single-port memory handshake signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;

    logic        m_req;
    logic        m_we;
    logic [1:0]  m_beop;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        stall;
    logic        bus_err;

    modport slave (
        input  if_req, if_addr, m_req, m_we, m_beop, m_addr, m_wdata,
               mem_rdata, mem_ack,
        output if_rdata, if_ready, m_rdata, m_ready,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, stall, bus_err
    );

    modport master (
        output if_req, if_addr, m_req, m_we, m_beop, m_addr, m_wdata,
               mem_rdata, mem_ack,
        input  if_rdata, if_ready, m_rdata, m_ready,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, stall, bus_err
    );

endinterface

// File: rtl/mem_port_arbiter_store_lane_align.sv
// Combinational byte-enable and write-data lane placement for a data access.
// Loads always read the full word.
module store_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic        we,
    input  logic [1:0]  beop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane
);

    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        if (we) begin
            case (beop)
                BE_SB: begin
                    be         = 4'b0001 << addr_lo;
                    wdata_lane = {4{wdata[7:0]}};
                end
                BE_SH: begin
                    be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata_lane = {2{wdata[15:0]}};
                end
                BE_SW:   ;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one memory port,
// alternating grants under contention and aborting accesses that never ack.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_M
    } state_e;

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_e      state, state_nxt;
    grant_e      last_grant, last_grant_nxt;
    logic [CW-1:0] wait_cnt;

    logic        cmd_we;
    logic [3:0]  cmd_be;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;

    logic [3:0]  al_be;
    logic [31:0] al_wdata;

    logic        busy, timeout_hit, done;
    logic        if_ready_c, m_ready_c;
    logic [31:0] if_rdata_c, m_rdata_c;

    store_lane_align u_align (
        .we         (bus.m_we),
        .beop       (bus.m_beop),
        .addr_lo    (bus.m_addr[1:0]),
        .wdata      (bus.m_wdata),
        .be         (al_be),
        .wdata_lane (al_wdata)
    );

    // wait_cnt counts already-elapsed ack-less cycles, so the TIMEOUT-th busy
    // cycle is the last one; an ack arriving in that cycle still wins.
    assign busy        = (state != IDLE);
    assign timeout_hit = busy && !bus.mem_ack && (32'(wait_cnt) + 32'd1 >= TIMEOUT);
    assign done        = busy && (bus.mem_ack || timeout_hit);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GRANT_IF;
            wait_cnt   <= '0;
            cmd_we     <= 1'b0;
            cmd_be     <= '0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            if (!busy)
                wait_cnt <= '0;
            else if (!done)
                wait_cnt <= wait_cnt + CW'(1);
            if (state == IDLE && state_nxt == BUSY_M) begin
                cmd_we    <= bus.m_we;
                cmd_be    <= al_be;
                cmd_addr  <= bus.m_addr & ~32'h3;
                cmd_wdata <= al_wdata;
            end else if (state == IDLE && state_nxt == BUSY_IF) begin
                cmd_we    <= 1'b0;
                cmd_be    <= 4'b1111;
                cmd_addr  <= bus.if_addr & ~32'h3;
                cmd_wdata <= '0;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        if_ready_c     = 1'b0;
        m_ready_c      = 1'b0;
        if_rdata_c     = '0;
        m_rdata_c      = '0;
        case (state)
            IDLE: begin
                if (bus.m_req && (!bus.if_req || last_grant == GRANT_IF))
                    state_nxt = BUSY_M;
                else if (bus.if_req)
                    state_nxt = BUSY_IF;
            end
            BUSY_IF: begin
                if (done) begin
                    if_ready_c     = 1'b1;
                    if_rdata_c     = bus.mem_ack ? bus.mem_rdata : '0;
                    state_nxt      = IDLE;
                    last_grant_nxt = GRANT_IF;
                end
            end
            BUSY_M: begin
                if (done) begin
                    m_ready_c      = 1'b1;
                    m_rdata_c      = bus.mem_ack ? bus.mem_rdata : '0;
                    state_nxt      = IDLE;
                    last_grant_nxt = GRANT_M;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.if_ready  = if_ready_c;
    assign bus.if_rdata  = if_rdata_c;
    assign bus.m_ready   = m_ready_c;
    assign bus.m_rdata   = m_rdata_c;
    assign bus.mem_req   = busy;
    assign bus.mem_we    = cmd_we;
    assign bus.mem_be    = cmd_be;
    assign bus.mem_addr  = cmd_addr;
    assign bus.mem_wdata = cmd_wdata;
    assign bus.bus_err   = timeout_hit;
    assign bus.stall     = (bus.if_req & ~if_ready_c) | (bus.m_req & ~m_ready_c);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT=3: lane alignment,
// alternation, timeout/ack race and reset during an access.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.m_req     = 1'b0;
        bus.m_we      = 1'b0;
        bus.m_beop    = BE_SW;
        bus.m_addr    = '0;
        bus.m_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_eq("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check_eq("rst_mem_be", 32'(bus.mem_be), 32'd0);
        check_eq("rst_ready", 32'({bus.if_ready, bus.m_ready}), 32'd0);
        check_eq("rst_bus_err", 32'(bus.bus_err), 32'd0);

        // Contention with ack held high: M first after reset, then alternation.
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0100;
        bus.m_req = 1'b1; bus.m_we = 1'b0; bus.m_addr = 32'h0000_0200;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_1111;
        #1;
        check_eq("idle_ack_ignored", 32'({bus.if_ready, bus.m_ready}), 32'd0);
        check_eq("idle_stall", 32'(bus.stall), 32'd1);
        for (int i = 0; i < 4; i++) begin
            logic m_turn;
            m_turn = (i % 2 == 0);
            tick();
            check_eq("alt_mem_req", 32'(bus.mem_req), 32'd1);
            check_eq("alt_addr", bus.mem_addr, m_turn ? 32'h0000_0200 : 32'h0000_0100);
            check_eq("alt_m_ready", 32'(bus.m_ready), 32'(m_turn));
            check_eq("alt_if_ready", 32'(bus.if_ready), 32'(!m_turn));
            check_eq("alt_rdata", m_turn ? bus.m_rdata : bus.if_rdata, 32'h1111_1111);
            check_eq("alt_stall", 32'(bus.stall), 32'd1);
            tick();
            check_eq("alt_gap_req", 32'(bus.mem_req), 32'd0);
        end
        clear_inputs();

        // Byte store, ack on the second busy cycle.
        tick();
        bus.m_req = 1'b1; bus.m_we = 1'b1; bus.m_beop = BE_SB;
        bus.m_addr = 32'h0000_1002; bus.m_wdata = 32'h0000_00AB;
        #1;
        check_eq("sb_req_idle", 32'(bus.mem_req), 32'd0);
        check_eq("sb_stall", 32'(bus.stall), 32'd1);
        tick();
        check_eq("sb_mem_req", 32'(bus.mem_req), 32'd1);
        check_eq("sb_be", 32'(bus.mem_be), 32'h4);
        check_eq("sb_wdata", bus.mem_wdata, 32'hABAB_ABAB);
        check_eq("sb_addr", bus.mem_addr, 32'h0000_1000);
        check_eq("sb_we", 32'(bus.mem_we), 32'd1);
        check_eq("sb_not_ready", 32'(bus.m_ready), 32'd0);
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_BEEF;
        #1;
        check_eq("sb_ready", 32'(bus.m_ready), 32'd1);
        check_eq("sb_stall_rel", 32'(bus.stall), 32'd0);
        tick();
        clear_inputs();
        #1;
        check_eq("sb_done_req", 32'(bus.mem_req), 32'd0);
        check_eq("sb_done_ready", 32'(bus.m_ready), 32'd0);

        // Halfword store with same-cycle ack (minimum latency).
        bus.m_req = 1'b1; bus.m_we = 1'b1; bus.m_beop = BE_SH;
        bus.m_addr = 32'h0000_2002; bus.m_wdata = 32'h0000_1234;
        tick();
        bus.mem_ack = 1'b1;
        #1;
        check_eq("sh_be", 32'(bus.mem_be), 32'hC);
        check_eq("sh_wdata", bus.mem_wdata, 32'h1234_1234);
        check_eq("sh_ready", 32'(bus.m_ready), 32'd1);
        tick();
        clear_inputs();

        // Misaligned load: full word enables, rdata passed through.
        bus.m_req = 1'b1; bus.m_we = 1'b0; bus.m_beop = BE_SB; bus.m_addr = 32'h0000_3001;
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
        #1;
        check_eq("ld_be", 32'(bus.mem_be), 32'hF);
        check_eq("ld_addr", bus.mem_addr, 32'h0000_3000);
        check_eq("ld_we", 32'(bus.mem_we), 32'd0);
        check_eq("ld_rdata", bus.m_rdata, 32'hCAFE_F00D);
        tick();
        clear_inputs();

        // Timeout: three busy cycles without ack, abort on the third.
        bus.m_req = 1'b1; bus.m_addr = 32'h0000_4000; bus.mem_rdata = 32'h5555_5555;
        tick();
        check_eq("to_c1_req", 32'(bus.mem_req), 32'd1);
        check_eq("to_c1_err", 32'({bus.bus_err, bus.m_ready}), 32'd0);
        tick();
        check_eq("to_c2_req", 32'(bus.mem_req), 32'd1);
        check_eq("to_c2_err", 32'({bus.bus_err, bus.m_ready}), 32'd0);
        tick();
        check_eq("to_c3_req", 32'(bus.mem_req), 32'd1);
        check_eq("to_c3_err", 32'(bus.bus_err), 32'd1);
        check_eq("to_c3_ready", 32'(bus.m_ready), 32'd1);
        check_eq("to_c3_rdata", bus.m_rdata, 32'd0);
        tick();
        clear_inputs();
        #1;
        check_eq("to_idle_req", 32'(bus.mem_req), 32'd0);
        check_eq("to_idle_err", 32'(bus.bus_err), 32'd0);

        // Ack on the last allowed cycle completes normally.
        bus.m_req = 1'b1; bus.m_addr = 32'h0000_5000;
        tick();
        tick();
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0077;
        #1;
        check_eq("race_err", 32'(bus.bus_err), 32'd0);
        check_eq("race_ready", 32'(bus.m_ready), 32'd1);
        check_eq("race_rdata", bus.m_rdata, 32'h0000_0077);
        tick();
        clear_inputs();

        // Reset in the middle of a word store; a late ack must be ignored.
        bus.m_req = 1'b1; bus.m_we = 1'b1; bus.m_beop = BE_SW;
        bus.m_addr = 32'h0000_6004; bus.m_wdata = 32'hA5A5_A5A5;
        tick();
        check_eq("sw_be", 32'(bus.mem_be), 32'hF);
        check_eq("sw_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
        reset = 1'b1;
        tick();
        check_eq("mid_rst_req", 32'(bus.mem_req), 32'd0);
        check_eq("mid_rst_be", 32'(bus.mem_be), 32'd0);
        reset = 1'b0;
        clear_inputs();
        bus.mem_ack = 1'b1;
        #1;
        check_eq("stray_ack_ready", 32'({bus.if_ready, bus.m_ready}), 32'd0);
        tick();
        check_eq("stray_ack_ready2", 32'({bus.if_ready, bus.m_ready}), 32'd0);
        check_eq("stray_ack_req", 32'(bus.mem_req), 32'd0);
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
